// File: rtl/video_rgb_gain_clamp_pkg.sv
// Shared register map and parameter storage types for the RGB gain/clamp block.
// Coefficient and offset registers hold a full write word; the top masks coeff to COEFF_BITS.
package video_rgb_gain_clamp_pkg;

  localparam int unsigned RegWordBits = 32;

  localparam logic [3:0] AddrCoeffBase  = 4'd0;
  localparam logic [3:0] AddrOffsetBase = 4'd4;
  localparam logic [3:0] AddrEnable     = 4'd8;
  localparam logic [3:0] AddrMaxClip    = 4'd9;
  localparam logic [3:0] AddrMinClip    = 4'd10;
  localparam logic [3:0] AddrUpdate     = 4'd15;

  typedef logic [RegWordBits-1:0]        coeff_t;
  typedef logic signed [RegWordBits-1:0] offset_t;

endpackage

// File: rtl/video_rgb_gain_clamp_unit.sv
// One colour channel: subtract offset, multiply by gain, round and clamp.
// Parameters travel with the pixel so a mid-pipeline transfer never mixes old and new values.
module video_rgb_gain_clamp_unit
  import video_rgb_gain_clamp_pkg::*;
#(
  parameter int unsigned S_CH_BITS = 11,
  parameter int unsigned M_CH_BITS = 10,
  parameter int unsigned COEFF_Q   = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cke,
  input  logic signed [S_CH_BITS-1:0] x,
  input  logic                        enable,
  input  coeff_t                      coeff,
  input  offset_t                     offset,
  input  logic [M_CH_BITS-1:0]        min_clip,
  input  logic [M_CH_BITS-1:0]        max_clip,
  output logic [M_CH_BITS-1:0]        y
);

  localparam int unsigned WordBits  = $bits(coeff_t);
  localparam int unsigned DiffBits  = ((S_CH_BITS > WordBits) ? S_CH_BITS : WordBits) + 1;
  localparam int unsigned ProdBits  = DiffBits + WordBits + 1;
  localparam int unsigned HalfLsb   = (2 ** COEFF_Q) >> 1;
  localparam logic signed [ProdBits-1:0] RoundHalf = ProdBits'(HalfLsb);

  logic signed [DiffBits-1:0] diff_d, diff_q;
  logic                       en_q;
  coeff_t                     coeff_q;
  logic [M_CH_BITS-1:0]       min1_q, max1_q, min2_q, max2_q;
  logic signed [ProdBits-1:0] diff_ext, gain_ext, prod_d, prod_q;
  logic signed [ProdBits-1:0] rounded, lo_ext, hi_ext;
  logic [M_CH_BITS-1:0]       y_d, y_q;

  always_comb begin
    diff_d = enable ? (DiffBits'(x) - DiffBits'(offset)) : DiffBits'(x);
  end

  // Bypass scales by 1.0 so the shared rounding stage returns x unchanged.
  always_comb begin
    diff_ext = ProdBits'(diff_q);
    gain_ext = ProdBits'($signed({1'b0, coeff_q}));
    prod_d   = en_q ? (diff_ext * gain_ext) : (diff_ext <<< COEFF_Q);
  end

  always_comb begin
    rounded = (prod_q + RoundHalf) >>> COEFF_Q;
    lo_ext  = ProdBits'($signed({1'b0, min2_q}));
    hi_ext  = ProdBits'($signed({1'b0, max2_q}));
    y_d     = rounded[M_CH_BITS-1:0];
    if (min2_q > max2_q) begin
      y_d = max2_q;
    end else if (rounded < lo_ext) begin
      y_d = min2_q;
    end else if (rounded > hi_ext) begin
      y_d = max2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      diff_q  <= '0;
      en_q    <= 1'b0;
      coeff_q <= '0;
      min1_q  <= '0;
      max1_q  <= '0;
      prod_q  <= '0;
      min2_q  <= '0;
      max2_q  <= '0;
      y_q     <= '0;
    end else if (cke) begin
      diff_q  <= diff_d;
      en_q    <= enable;
      coeff_q <= coeff;
      min1_q  <= min_clip;
      max1_q  <= max_clip;
      prod_q  <= prod_d;
      min2_q  <= min1_q;
      max2_q  <= max1_q;
      y_q     <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/video_rgb_gain_clamp.sv
// Per-channel gain/offset/clamp with shadowed parameters that switch at a frame start.
// Three cke-qualified stages; framing and user sideband are delayed alongside the data.
module video_rgb_gain_clamp
  import video_rgb_gain_clamp_pkg::*;
#(
  parameter int unsigned CH_DEPTH    = 4,
  parameter int unsigned S_CH_BITS   = 11,
  parameter int unsigned M_CH_BITS   = 10,
  parameter int unsigned COEFF_BITS  = 16,
  parameter int unsigned COEFF_Q     = 12,
  parameter int unsigned USER_BITS   = 1,
  parameter int unsigned INIT_COEFF  = 1 << COEFF_Q,
  parameter int          INIT_OFFSET = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cke,
  input  logic                            in_update_req,
  input  logic                            reg_wr_en,
  input  logic [3:0]                      reg_addr,
  input  logic [31:0]                     reg_wdata,
  output logic                            update_ack,
  input  logic                            s_row_first,
  input  logic                            s_row_last,
  input  logic                            s_col_first,
  input  logic                            s_col_last,
  input  logic                            s_de,
  input  logic                            s_valid,
  input  logic [USER_BITS-1:0]            s_user,
  input  logic [CH_DEPTH*S_CH_BITS-1:0]   s_data,
  output logic                            m_row_first,
  output logic                            m_row_last,
  output logic                            m_col_first,
  output logic                            m_col_last,
  output logic                            m_de,
  output logic                            m_valid,
  output logic [USER_BITS-1:0]            m_user,
  output logic [CH_DEPTH*M_CH_BITS-1:0]   m_data
);

  localparam coeff_t  CoeffMask  = coeff_t'((64'(1) << COEFF_BITS) - 64'(1));
  localparam coeff_t  CoeffInit  = coeff_t'(INIT_COEFF) & CoeffMask;
  localparam offset_t OffsetInit = offset_t'(INIT_OFFSET);
  localparam int unsigned FrameBits = 6 + USER_BITS;
  localparam int unsigned Stages    = 3;

  coeff_t               sh_coeff_q [CH_DEPTH];
  coeff_t               sh_coeff_d [CH_DEPTH];
  coeff_t               act_coeff_q [CH_DEPTH];
  coeff_t               eff_coeff [CH_DEPTH];
  offset_t              sh_offset_q [CH_DEPTH];
  offset_t              sh_offset_d [CH_DEPTH];
  offset_t              act_offset_q [CH_DEPTH];
  offset_t              eff_offset [CH_DEPTH];
  logic                 sh_enable_q, sh_enable_d, act_enable_q, eff_enable;
  logic [M_CH_BITS-1:0] sh_max_q, sh_max_d, act_max_q, eff_max;
  logic [M_CH_BITS-1:0] sh_min_q, sh_min_d, act_min_q, eff_min;
  logic                 pending_q, pending_d, ack_q;
  logic                 wr_update, xfer;
  logic [FrameBits-1:0] frame_in;
  logic [FrameBits-1:0] frame_q [Stages];

  always_comb begin
    sh_coeff_d  = sh_coeff_q;
    sh_offset_d = sh_offset_q;
    sh_enable_d = sh_enable_q;
    sh_max_d    = sh_max_q;
    sh_min_d    = sh_min_q;
    if (reg_wr_en) begin
      for (int unsigned c = 0; c < CH_DEPTH; c++) begin
        if (reg_addr == 4'(AddrCoeffBase + c)) sh_coeff_d[c] = coeff_t'(reg_wdata) & CoeffMask;
        if (reg_addr == 4'(AddrOffsetBase + c)) sh_offset_d[c] = offset_t'(reg_wdata);
      end
      if (reg_addr == AddrEnable)  sh_enable_d = reg_wdata[0];
      if (reg_addr == AddrMaxClip) sh_max_d    = reg_wdata[M_CH_BITS-1:0];
      if (reg_addr == AddrMinClip) sh_min_d    = reg_wdata[M_CH_BITS-1:0];
    end
  end

  assign wr_update = reg_wr_en && (reg_addr == AddrUpdate);
  assign xfer      = cke && s_valid && s_de && s_row_first && s_col_first && pending_q;

  // A request in the transfer cycle re-arms pending for the following frame.
  always_comb begin
    pending_d = pending_q;
    if (xfer) pending_d = 1'b0;
    if ((cke && in_update_req) || wr_update) pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < CH_DEPTH; c++) begin
        sh_coeff_q[c]   <= CoeffInit;
        act_coeff_q[c]  <= CoeffInit;
        sh_offset_q[c]  <= OffsetInit;
        act_offset_q[c] <= OffsetInit;
      end
      sh_enable_q  <= 1'b1;
      act_enable_q <= 1'b1;
      sh_max_q     <= '1;
      act_max_q    <= '1;
      sh_min_q     <= '0;
      act_min_q    <= '0;
      pending_q    <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      sh_coeff_q  <= sh_coeff_d;
      sh_offset_q <= sh_offset_d;
      sh_enable_q <= sh_enable_d;
      sh_max_q    <= sh_max_d;
      sh_min_q    <= sh_min_d;
      pending_q   <= pending_d;
      ack_q       <= xfer;
      if (xfer) begin
        act_coeff_q  <= sh_coeff_q;
        act_offset_q <= sh_offset_q;
        act_enable_q <= sh_enable_q;
        act_max_q    <= sh_max_q;
        act_min_q    <= sh_min_q;
      end
    end
  end

  // The transfer pixel itself must already see the shadow values.
  always_comb begin
    eff_coeff  = xfer ? sh_coeff_q  : act_coeff_q;
    eff_offset = xfer ? sh_offset_q : act_offset_q;
    eff_enable = xfer ? sh_enable_q : act_enable_q;
    eff_max    = xfer ? sh_max_q    : act_max_q;
    eff_min    = xfer ? sh_min_q    : act_min_q;
  end

  assign update_ack = ack_q;

  assign frame_in = {s_row_first, s_row_last, s_col_first, s_col_last, s_de, s_valid, s_user};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < Stages; i++) frame_q[i] <= '0;
    end else if (cke) begin
      frame_q[0] <= frame_in;
      for (int unsigned i = 1; i < Stages; i++) frame_q[i] <= frame_q[i-1];
    end
  end

  assign {m_row_first, m_row_last, m_col_first, m_col_last, m_de, m_valid, m_user} =
      frame_q[Stages-1];

  for (genvar c = 0; c < CH_DEPTH; c++) begin : g_ch
    video_rgb_gain_clamp_unit #(
      .S_CH_BITS (S_CH_BITS),
      .M_CH_BITS (M_CH_BITS),
      .COEFF_Q   (COEFF_Q)
    ) u_unit (
      .clk      (clk),
      .reset    (reset),
      .cke      (cke),
      .x        (s_data[c*S_CH_BITS +: S_CH_BITS]),
      .enable   (eff_enable),
      .coeff    (eff_coeff[c]),
      .offset   (eff_offset[c]),
      .min_clip (eff_min),
      .max_clip (eff_max),
      .y        (m_data[c*M_CH_BITS +: M_CH_BITS])
    );
  end

endmodule

// File: tb/tb_video_rgb_gain_clamp.sv
// Directed bench for video_rgb_gain_clamp: register updates, gain/clip corners,
// cke stalls against a reference model, and mid-frame reset.
module tb_video_rgb_gain_clamp;

  logic        clk = 1'b0;
  logic        reset, cke, in_update_req, reg_wr_en;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        update_ack;
  logic        s_row_first, s_row_last, s_col_first, s_col_last, s_de, s_valid;
  logic [0:0]  s_user;
  logic [43:0] s_data;
  logic        m_row_first, m_row_last, m_col_first, m_col_last, m_de, m_valid;
  logic [0:0]  m_user;
  logic [39:0] m_data;
  logic [6:0]  m_fr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign m_fr = {m_row_first, m_row_last, m_col_first, m_col_last, m_de, m_valid, m_user};

  video_rgb_gain_clamp dut (
    .clk           (clk),
    .reset         (reset),
    .cke           (cke),
    .in_update_req (in_update_req),
    .reg_wr_en     (reg_wr_en),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .update_ack    (update_ack),
    .s_row_first   (s_row_first),
    .s_row_last    (s_row_last),
    .s_col_first   (s_col_first),
    .s_col_last    (s_col_last),
    .s_de          (s_de),
    .s_valid       (s_valid),
    .s_user        (s_user),
    .s_data        (s_data),
    .m_row_first   (m_row_first),
    .m_row_last    (m_row_last),
    .m_col_first   (m_col_first),
    .m_col_last    (m_col_last),
    .m_de          (m_de),
    .m_valid       (m_valid),
    .m_user        (m_user),
    .m_data        (m_data)
  );

  function automatic logic [43:0] pack_s(int a0, int a1, int a2, int a3);
    return {11'(a3), 11'(a2), 11'(a1), 11'(a0)};
  endfunction

  function automatic logic [39:0] pack_m(int a0, int a1, int a2, int a3);
    return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  // Reference: y = clamp(round(((x - off) * coeff) / 4096), mn, mx); min > max yields max.
  function automatic int model(int x, int off, int coeff, int mn, int mx);
    longint p, r;
    p = longint'(x - off) * longint'(coeff);
    r = (p + 2048) >>> 12;
    if (mn > mx) return mx;
    if (r < mn) return mn;
    if (r > mx) return mx;
    return int'(r);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
    s_valid   = 1'b0;
    reg_wr_en = 1'b1;
    reg_addr  = addr;
    reg_wdata = data;
    tick();
    reg_wr_en = 1'b0;
  endtask

  task automatic set_pix(input logic first, input logic [43:0] d);
    s_row_first = first;
    s_col_first = first;
    s_row_last  = 1'b0;
    s_col_last  = 1'b0;
    s_de        = 1'b1;
    s_valid     = 1'b1;
    s_user      = 1'b0;
    s_data      = d;
  endtask

  // Frame-start pixel then one more tick; caller ticks once more to see it at the output.
  task automatic frame_start(input logic [43:0] d);
    set_pix(1'b1, d);
    tick();
    set_pix(1'b0, d);
    tick();
  endtask

  typedef struct packed {
    logic [6:0]  fr;
    logic [39:0] data;
  } ent_t;

  ent_t        pipe [3];
  int          offs [4];
  int          xs [4];
  int          ramp;
  logic [6:0]  fr_in;
  logic [39:0] exp_d;

  initial begin
    reset = 1'b1; cke = 1'b1; in_update_req = 1'b0;
    reg_wr_en = 1'b0; reg_addr = '0; reg_wdata = '0;
    s_row_first = 1'b0; s_row_last = 1'b0; s_col_first = 1'b0; s_col_last = 1'b0;
    s_de = 1'b0; s_valid = 1'b0; s_user = 1'b0; s_data = '0;
    tick();
    tick();
    check("rst_valid", 64'(m_valid), 64'(0));
    check("rst_frame", 64'(m_fr), 64'(0));
    check("rst_data", 64'(m_data), 64'(0));
    check("rst_ack", 64'(update_ack), 64'(0));

    // Defaults pass data through with three-cycle latency.
    reset = 1'b0;
    set_pix(1'b0, pack_s(500, 500, 500, 500));
    tick();
    tick();
    check("lat_not_yet", 64'(m_valid), 64'(0));
    tick();
    check("def_valid", 64'(m_valid), 64'(1));
    check("def_data", 64'(m_data), 64'(pack_m(500, 500, 500, 500)));

    // Shadow writes must not take effect without an update.
    write_reg(4'd0, 32'd8192);
    write_reg(4'd4, 32'd66);
    set_pix(1'b0, pack_s(100, 100, 100, 100));
    tick(); tick(); tick();
    check("shadow_hold", 64'(m_data), 64'(pack_m(100, 100, 100, 100)));
    check("no_ack", 64'(update_ack), 64'(0));
    in_update_req = 1'b1;
    tick();
    in_update_req = 1'b0;
    set_pix(1'b1, pack_s(100, 100, 100, 100));
    tick();
    check("ack_pulse", 64'(update_ack), 64'(1));
    set_pix(1'b0, pack_s(100, 100, 100, 100));
    tick();
    check("ack_one_cycle", 64'(update_ack), 64'(0));
    check("pre_xfer_pix", 64'(m_data), 64'(pack_m(100, 100, 100, 100)));
    tick();
    check("xfer_pix_data", 64'(m_data), 64'(pack_m(68, 100, 100, 100)));
    check("xfer_pix_frame", 64'({m_row_first, m_col_first}), 64'(2'b11));

    // Gain 4.0 clips high/low; gain 1.5 checks round-half-up.
    write_reg(4'd0, 32'd16384);
    write_reg(4'd1, 32'd16384);
    write_reg(4'd2, 32'd16384);
    write_reg(4'd3, 32'd6144);
    write_reg(4'd4, 32'd0);
    write_reg(4'd15, 32'd0);
    frame_start(pack_s(400, -5, 100, 101));
    tick();
    check("gain_clip", 64'(m_data), 64'(pack_m(1023, 0, 400, 152)));

    // Bypass mode, clip window [20,255].
    write_reg(4'd8, 32'd0);
    write_reg(4'd9, 32'd255);
    write_reg(4'd10, 32'd20);
    write_reg(4'd15, 32'd0);
    frame_start(pack_s(300, -5, 100, 10));
    tick();
    check("bypass_clip", 64'(m_data), 64'(pack_m(255, 20, 100, 20)));

    // Inverted window resolves to max_clip.
    write_reg(4'd10, 32'd300);
    write_reg(4'd15, 32'd0);
    frame_start(pack_s(300, -5, 100, 10));
    tick();
    check("min_gt_max", 64'(m_data), 64'(pack_m(255, 255, 255, 255)));

    // Configuration for the cke stall test.
    offs = '{0, 10, -10, 100};
    write_reg(4'd8, 32'd1);
    for (int c = 0; c < 4; c++) begin
      write_reg(4'(c), 32'd6144);
      write_reg(4'(4 + c), 32'(offs[c]));
    end
    write_reg(4'd9, 32'd1000);
    write_reg(4'd10, 32'd5);
    write_reg(4'd15, 32'd0);
    frame_start(pack_s(0, 0, 0, 0));
    tick();
    check("cfg_pix", 64'(m_data), 64'(pack_m(5, 5, 15, 5)));

    s_valid = 1'b0; s_de = 1'b0; s_row_first = 1'b0; s_col_first = 1'b0; s_user = 1'b0;
    tick(); tick(); tick();
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    ramp = 0;
    for (int n = 0; n < 60; n++) begin
      cke = ($urandom_range(0, 2) != 0);
      for (int c = 0; c < 4; c++) xs[c] = (ramp % 48) * 20 + c * 30 - 60;
      s_data      = pack_s(xs[0], xs[1], xs[2], xs[3]);
      s_valid     = (ramp % 5) != 4;
      s_de        = 1'b1;
      s_col_first = (ramp % 8) == 0;
      s_col_last  = (ramp % 8) == 7;
      s_row_first = ramp < 8;
      s_row_last  = 1'b0;
      s_user      = 1'(ramp & 1);
      fr_in = {s_row_first, s_row_last, s_col_first, s_col_last, s_de, s_valid, s_user};
      exp_d = pack_m(model(xs[0], offs[0], 6144, 5, 1000), model(xs[1], offs[1], 6144, 5, 1000),
                     model(xs[2], offs[2], 6144, 5, 1000), model(xs[3], offs[3], 6144, 5, 1000));
      tick();
      if (cke) begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = '{fr: fr_in, data: exp_d};
        ramp++;
      end
      check("cke_frame", 64'(m_fr), 64'(pipe[2].fr));
      if (pipe[2].fr[1]) check("cke_data", 64'(m_data), 64'(pipe[2].data));
    end

    // Mid-frame reset with an update pending.
    cke = 1'b1;
    set_pix(1'b0, pack_s(200, 200, 200, 200));
    tick(); tick();
    in_update_req = 1'b1;
    tick();
    in_update_req = 1'b0;
    reset = 1'b1;
    tick();
    check("mid_rst_frame", 64'(m_fr), 64'(0));
    check("mid_rst_data", 64'(m_data), 64'(0));
    check("mid_rst_ack", 64'(update_ack), 64'(0));
    reset = 1'b0;
    set_pix(1'b1, pack_s(500, 500, 500, 500));
    tick();
    check("pending_cleared", 64'(update_ack), 64'(0));
    set_pix(1'b0, pack_s(500, 500, 500, 500));
    tick();
    check("flush_lat", 64'(m_valid), 64'(0));
    tick();
    check("flush_valid", 64'(m_valid), 64'(1));
    check("flush_defaults", 64'(m_data), 64'(pack_m(500, 500, 500, 500)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
